// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle MIPS-subset core: LW, SW, ADDI, BEQ, J, R-type ADD/SUB/AND/OR/SLT
//   and a HALT word (0xFFFFFFFF). Each instruction takes 3-5 states. Instruction
//   fetches and data accesses share one memory port with a req/ready handshake.
//
//   Optional feature: define MULTICYCLE_BNE_EN to decode BNE (opcode 0x05);
//   otherwise opcode 0x05 halts the core with illegal=1.
//
// Parameters
//   M        data/register/address width (>= 32)
//   N        register-address width (2^N registers)
//   RESET_PC PC after reset (word aligned)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   mem_req    memory request, held until mem_ready
//   mem_we     1 = write, 0 = read (valid with mem_req)
//   mem_addr   byte address, word aligned
//   mem_wdata  store data (valid with mem_req & mem_we)
//   mem_rdata  read data, sampled when mem_req & mem_ready
//   mem_ready  transfer completes this cycle
//   pc         current PC
//   halted     core stopped (cleared only by reset)
//   illegal    halt caused by an unsupported opcode or funct
module multicycle_datapath #(
  parameter int unsigned  M        = 32,
  parameter int unsigned  N        = 5,
  parameter logic [M-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic         mem_we,
  output logic [M-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  input  logic [M-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [M-1:0] pc,
  output logic         halted,
  output logic         illegal
);

  localparam int unsigned NREG = 1 << N;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [M-1:0] r_pc;
  logic [31:0]  r_ir;
  logic [M-1:0] r_a;
  logic [M-1:0] r_b;
  logic [M-1:0] r_aluout;
  logic [M-1:0] r_mdr;
  logic [M-1:0] r_regs [NREG];
  logic         r_halted;
  logic         r_illegal;
  logic         r_ill_cause;
  // Keeps the memory port quiet during reset and for the first edge after it.
  logic         r_active;

  logic [5:0]   w_op;
  logic [5:0]   w_funct;
  logic [N-1:0] w_rs;
  logic [N-1:0] w_rt;
  logic [N-1:0] w_rd;
  logic [M-1:0] w_sext;
  logic [M-1:0] w_rd_rs;
  logic [M-1:0] w_rd_rt;
  logic [M-1:0] w_br_target;
  logic [M-1:0] w_j_target;
  logic         w_br_taken;
  logic         w_is_halt;
  logic [M-1:0] w_alu;
  logic         w_funct_ok;
  logic         w_to_illegal;

  logic         w_req;
  logic         w_we;
  logic [M-1:0] w_addr;
  logic [M-1:0] w_wdata;
  logic         w_rf_we;
  logic [N-1:0] w_rf_waddr;
  logic [M-1:0] w_rf_wdata;

  logic         w_unused;

  // Instruction fields and derived operands
  assign w_op        = r_ir[31:26];
  assign w_funct     = r_ir[5:0];
  assign w_rs        = r_ir[21 +: N];
  assign w_rt        = r_ir[16 +: N];
  assign w_rd        = r_ir[11 +: N];
  assign w_sext      = {{(M-16){r_ir[15]}}, r_ir[15:0]};
  assign w_rd_rs     = (w_rs == '0) ? '0 : r_regs[w_rs];
  assign w_rd_rt     = (w_rt == '0) ? '0 : r_regs[w_rt];
  // r_pc already holds PC+4 once FETCH completes.
  assign w_br_target = r_pc + {w_sext[M-3:0], 2'b00};
  assign w_j_target  = {r_pc[M-1:28], r_ir[25:0], 2'b00};
  assign w_is_halt   = (r_ir == 32'hFFFF_FFFF);

`ifdef MULTICYCLE_BNE_EN
  assign w_br_taken = (w_op == OP_BNE) ? (r_a != r_b) : (r_a == r_b);
`else
  assign w_br_taken = (r_a == r_b);
`endif

  always_comb begin
    w_alu      = '0;
    w_funct_ok = 1'b1;
    case (w_funct)
      FN_ADD:  w_alu = r_a + r_b;
      FN_SUB:  w_alu = r_a - r_b;
      FN_AND:  w_alu = r_a & r_b;
      FN_OR:   w_alu = r_a | r_b;
      FN_SLT:  w_alu = {{(M-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_funct_ok = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next       = r_state;
    w_to_illegal = 1'b0;
    case (r_state)
      S_FETCH:  if (w_req && mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          case (w_op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_EXEC;
            OP_ADDI:      w_next = S_ADDIEX;
            OP_BEQ:       w_next = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
            OP_BNE:       w_next = S_BRANCH;
`endif
            OP_J:         w_next = S_JUMP;
            default: begin
              w_next       = S_HALT;
              w_to_illegal = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR: w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_req && mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (w_req && mem_ready) w_next = S_FETCH;
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC: begin
        if (w_funct_ok) begin
          w_next = S_ALUWB;
        end else begin
          w_next       = S_HALT;
          w_to_illegal = 1'b1;
        end
      end
      S_ALUWB:  w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // FSM: outputs (memory port and register-file write port)
  always_comb begin
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    w_rf_we    = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    case (r_state)
      S_FETCH: begin
        w_req  = r_active;
        w_addr = r_active ? r_pc : '0;
      end
      S_MEMRD: begin
        w_req  = 1'b1;
        w_addr = r_aluout;
      end
      S_MEMWR: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_aluout;
        w_wdata = r_b;
      end
      S_MEMWB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rt;
        w_rf_wdata = r_mdr;
      end
      S_ALUWB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rd;
        w_rf_wdata = r_aluout;
      end
      S_ADDIWB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rt;
        w_rf_wdata = r_aluout;
      end
      default: ;
    endcase
  end

  assign mem_req   = w_req;
  assign mem_we    = w_we;
  assign mem_addr  = {w_addr[M-1:2], 2'b00};
  assign mem_wdata = w_wdata;
  assign pc        = r_pc;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_aluout    <= '0;
      r_mdr       <= '0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_ill_cause <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_to_illegal) r_ill_cause <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (w_req && mem_ready) begin
            r_ir <= mem_rdata[31:0];
            r_pc <= r_pc + M'(4);
          end
        end
        S_DECODE: begin
          r_a <= w_rd_rs;
          r_b <= w_rd_rt;
        end
        S_MEMADR: r_aluout <= r_a + w_sext;
        S_MEMRD:  if (w_req && mem_ready) r_mdr <= mem_rdata;
        S_EXEC:   r_aluout <= w_alu;
        S_ADDIEX: r_aluout <= r_a + w_sext;
        S_BRANCH: if (w_br_taken) r_pc <= w_br_target;
        S_JUMP:   r_pc <= w_j_target;
        S_HALT: begin
          // Flags follow the HALT state by one cycle.
          r_halted  <= 1'b1;
          r_illegal <= r_ill_cause;
        end
        default: ;
      endcase
    end
  end

  // Register file; register 0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_rf_we && (w_rf_waddr != '0)) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // Shamt and the alignment bits of addresses are intentionally ignored.
  assign w_unused = ^{r_ir, w_addr[1:0]};

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        halted;
  logic        illegal;

  logic [31:0] mem [256];
  logic [31:0] rd_addrs [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mode    = 0;   // 0 zero-wait, 1 random waits, 2 stall reads of 0x40
  int          lows    = 0;
  int          viol    = 0;
  int          cyc     = 0;
  logic        found;
  logic        pend;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_we;
  int          req_cnt;

  assign mem_rdata = mem[mem_addr[9:2]];

  multicycle_datapath #(.M(32), .N(5), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] r_type(input int rd, input int rs, input int rt,
                                         input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Memory: completes transfers at the negedge before the active edge, checks
  // request stability while stalled, and picks mem_ready just after each edge.
  task automatic mem_model;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && mem_req) begin
        if (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) viol++;
      end
      pend    = mem_req && !mem_ready;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
      if (mem_req && mem_ready) begin
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        else        rd_addrs.push_back(mem_addr);
      end
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          if (lows < 3 && $urandom_range(0, 1) == 0) begin
            mem_ready = 1'b0;
            lows++;
          end else begin
            mem_ready = 1'b1;
            lows = 0;
          end
        end
        2:       mem_ready = !(mem_req && mem_addr == 32'h40);
        default: mem_ready = 1'b1;
      endcase
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
    rd_addrs.delete();
  endtask

  task automatic run_to_halt;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("req_after_reset", {31'd0, mem_req}, 32'd1);
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic load_lwsw(input logic extra_sw);
    clear_mem();
    mem[0] = i_type(6'h08, 0, 1, 16'h0040);
    mem[1] = i_type(6'h08, 0, 2, 16'hFFFB);
    mem[2] = i_type(6'h2B, 1, 2, 16'h0000);
    mem[3] = i_type(6'h23, 1, 3, 16'h0000);
    if (extra_sw) begin
      mem[4] = i_type(6'h2B, 1, 3, 16'h0004);
      mem[5] = 32'hFFFF_FFFF;
    end else begin
      mem[4] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic load_rtype;
    clear_mem();
    mem[0]  = i_type(6'h08, 0, 1, 16'd7);
    mem[1]  = i_type(6'h08, 0, 2, 16'd9);
    mem[2]  = r_type(4, 1, 2, 6'h20);
    mem[3]  = r_type(5, 1, 2, 6'h22);
    mem[4]  = r_type(6, 1, 2, 6'h24);
    mem[5]  = r_type(7, 1, 2, 6'h25);
    mem[6]  = r_type(8, 2, 1, 6'h2A);
    mem[7]  = r_type(0, 1, 2, 6'h20);
    mem[8]  = r_type(9, 1, 2, 6'h2A);
    mem[9]  = i_type(6'h2B, 0, 4, 16'h0080);
    mem[10] = i_type(6'h2B, 0, 5, 16'h0084);
    mem[11] = i_type(6'h2B, 0, 6, 16'h0088);
    mem[12] = i_type(6'h2B, 0, 7, 16'h008C);
    mem[13] = i_type(6'h2B, 0, 8, 16'h0090);
    mem[14] = i_type(6'h2B, 0, 0, 16'h0094);
    mem[15] = i_type(6'h2B, 0, 9, 16'h0098);
    mem[16] = 32'hFFFF_FFFF;
  endtask

  task automatic check_rtype(input string pfx);
    chk({pfx, "_add"},   mem[32], 32'd16);
    chk({pfx, "_sub"},   mem[33], 32'hFFFF_FFFE);
    chk({pfx, "_and"},   mem[34], 32'd1);
    chk({pfx, "_or"},    mem[35], 32'd15);
    chk({pfx, "_slt0"},  mem[36], 32'd0);
    chk({pfx, "_r0"},    mem[37], 32'd0);
    chk({pfx, "_slt1"},  mem[38], 32'd1);
    chk({pfx, "_pc"},    pc,      32'h44);
    chk({pfx, "_legal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    mem_ready = 1'b1;
    clear_mem();
    fork
      mem_model();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",     {31'd0, mem_req}, 32'd0);
    chk("rst_we",      {31'd0, mem_we},  32'd0);
    chk("rst_addr",    mem_addr,         32'd0);
    chk("rst_wdata",   mem_wdata,        32'd0);
    chk("rst_pc",      pc,               32'd0);
    chk("rst_halted",  {31'd0, halted},  32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // LW/SW round trip, zero wait: 4+4+4+5+3 cycles
    mode = 0;
    load_lwsw(1'b0);
    run_to_halt();
    chk("lwsw_cycles", 32'(cyc), 32'd20);
    chk("lwsw_mem40",  mem[16],  32'hFFFF_FFFB);
    chk("lwsw_pc",     pc,       32'h14);
    chk("lwsw_legal",  {31'd0, illegal}, 32'd0);

    // R-type ALU operations, zero wait
    load_rtype();
    run_to_halt();
    check_rtype("rt");

    // Branches and jump: BEQ taken, BEQ not taken, J 0x10
    clear_mem();
    mem[0]  = i_type(6'h08, 0, 1, 16'd3);
    mem[1]  = i_type(6'h08, 0, 2, 16'd3);
    mem[2]  = i_type(6'h04, 1, 2, 16'd2);
    mem[3]  = i_type(6'h08, 0, 10, 16'd1);
    mem[4]  = i_type(6'h08, 0, 10, 16'd2);
    mem[5]  = i_type(6'h04, 1, 0, 16'd5);
    mem[6]  = {6'h02, 26'h10};
    mem[7]  = i_type(6'h08, 0, 10, 16'd3);
    mem[16] = i_type(6'h08, 0, 11, 16'h0055);
    mem[17] = i_type(6'h2B, 0, 10, 16'h00A0);
    mem[18] = i_type(6'h2B, 0, 11, 16'h00A4);
    mem[19] = 32'hFFFF_FFFF;
    run_to_halt();
    chk("br_cycles",    32'(cyc),            32'd32);
    chk("br_nfetch",    32'(rd_addrs.size()), 32'd9);
    chk("beq_taken",    rd_addrs[3],         32'h14);
    chk("beq_nottaken", rd_addrs[4],         32'h18);
    chk("j_target",     rd_addrs[5],         32'h40);
    chk("br_skip",      mem[40],             32'd0);
    chk("j_dest",       mem[41],             32'h55);
    chk("br_pc",        pc,                  32'h50);

    // Wait states: same architectural results
    mode = 1;
    load_lwsw(1'b1);
    run_to_halt();
    chk("ws_mem40", mem[16], 32'hFFFF_FFFB);
    chk("ws_mem44", mem[17], 32'hFFFF_FFFB);
    chk("ws_pc",    pc,      32'h18);
    load_rtype();
    run_to_halt();
    check_rtype("ws_rt");
    mode = 0;

    // Illegal opcode 0x3F
    clear_mem();
    mem[0] = 32'hFC00_0000;
    run_to_halt();
    chk("ill_cycles",  32'(cyc),          32'd3);
    chk("ill_illegal", {31'd0, illegal},  32'd1);
    chk("ill_pc",      pc,                32'h4);
    req_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req) req_cnt++;
    end
    chk("ill_noreq", 32'(req_cnt), 32'd0);

    // Illegal funct
    clear_mem();
    mem[0] = r_type(1, 0, 0, 6'h21);
    run_to_halt();
    chk("illfn_cycles",  32'(cyc),         32'd4);
    chk("illfn_illegal", {31'd0, illegal}, 32'd1);

    // BNE
    clear_mem();
    mem[0] = i_type(6'h08, 0, 1, 16'd1);
    mem[1] = i_type(6'h05, 1, 0, 16'd1);
    mem[2] = i_type(6'h08, 0, 10, 16'd7);
    mem[3] = i_type(6'h2B, 0, 10, 16'h00B0);
    mem[4] = 32'hFFFF_FFFF;
    run_to_halt();
`ifdef MULTICYCLE_BNE_EN
    chk("bne_cycles",  32'(cyc),         32'd14);
    chk("bne_illegal", {31'd0, illegal}, 32'd0);
    chk("bne_taken",   mem[44],          32'd0);
`else
    chk("bne_illegal", {31'd0, illegal}, 32'd1);
    chk("bne_pc",      pc,               32'h8);
    chk("bne_nostore", mem[44],          32'hDEAD_BEEF);
`endif

    // Reset while a load is stalled
    clear_mem();
    mem[0]  = i_type(6'h08, 0, 1, 16'h0040);
    mem[1]  = i_type(6'h23, 1, 3, 16'h0000);
    mem[2]  = i_type(6'h2B, 1, 3, 16'h0004);
    mem[3]  = 32'hFFFF_FFFF;
    mem[16] = 32'h1234_5678;
    mode = 2;
    rst  = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h40) found = 1'b1;
    end
    chk("mrd_reached", {31'd0, found}, 32'd1);
    repeat (2) @(negedge clk);
    chk("mrd_pending", {31'd0, mem_req}, 32'd1);
    chk("mrd_addr",    mem_addr,         32'h40);
    chk("mrd_pc",      pc,               32'h8);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req",  {31'd0, mem_req}, 32'd0);
    chk("arst_pc",   pc,               32'd0);
    chk("arst_addr", mem_addr,         32'd0);
    mode = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("refetch_req",  {31'd0, mem_req}, 32'd1);
    chk("refetch_addr", mem_addr,         32'd0);
    chk("refetch_we",   {31'd0, mem_we},  32'd0);
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("refetch_halt", {31'd0, halted}, 32'd1);
    chk("refetch_load", mem[17],         32'h1234_5678);
    chk("refetch_pc",   pc,              32'h10);

    chk("stable_handshake", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle MIPS-subset processor core: register file, sign extension, ALU and PC logic, sequenced by an internal FSM controller. One instruction is executed over 3–5 states. All fetches and data accesses share one external memory port with a req/ready handshake. It supersedes the single-cycle load-only datapath as the core of the CPU practice series, with store, R-type, immediate, branch and jump support and wait-state tolerant memory.

## Interface
- M, 32, data/register/address width; M ≥ 32; the instruction is the low 32 bits of mem_rdata.
- N, 5, register-address width (1..5); 2^N registers; rs/rt/rd fields are truncated to their low N bits.
- RESET_PC, 0, PC value after reset; must be word-aligned.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  M  byte address; the low 2 bits are always 0.
- mem_wdata  out  M  store data; valid while mem_req & mem_we.
- mem_rdata  in  M  read data; sampled on the edge where mem_req & mem_ready.
- mem_ready  in  1  transfer complete this cycle.
- pc  out  M  current PC.
- halted  out  1  core stopped; only reset clears it.
- illegal  out  1  the halt was caused by an unsupported opcode or funct.

## Operation
- Supported instructions:
  - LW, opcode 0x23.
  - SW, opcode 0x2B.
  - ADDI, opcode 0x08.
  - BEQ, opcode 0x04.
  - J, opcode 0x02.
  - R-type, opcode 0x00, funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed).
  - HALT: instruction word 0xFFFFFFFF.
- Register 0 reads 0. Writes to register 0 are discarded.
- Arithmetic is M-bit two's-complement and wraps with no overflow trap. imm16 is sign-extended to M bits.
- Branch target = PC+4 + (sext(imm16) << 2). Jump target = {PC+4[M-1:28], addr26, 2'b00}.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.
- State transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. When mem_ready: latch IR, PC ← PC+4, go to DECODE.
  - DECODE: latch A=R[rs], B=R[rt]. Dispatch on opcode:
    - LW/SW → MEMADR.
    - R-type → EXEC.
    - ADDI → ADDIEX.
    - BEQ → BRANCH.
    - J → JUMP.
    - HALT word → HALT.
    - Anything else → HALT with illegal=1.
  - MEMADR: ALUOut ← A+sext. LW → MEMRD; SW → MEMWR.
  - MEMRD: read at ALUOut. When mem_ready: latch MDR, go to MEMWB.
  - MEMWR: write B to ALUOut. When mem_ready → FETCH.
  - MEMWB: R[rt] ← MDR, then FETCH.
  - EXEC: ALUOut ← A op B. An unknown funct → HALT with illegal=1.
  - ALUWB: R[rd] ← ALUOut, then FETCH.
  - ADDIEX → ADDIWB: R[rt] ← ALUOut, then FETCH.
  - BRANCH: if A==B, PC ← target. Then FETCH.
  - JUMP: PC ← target, then FETCH.
  - HALT: absorbing state; mem_req=0.
- The register file is written only in MEMWB, ALUWB and ADDIWB. In every other state, state registers hold their values.

## Timing
- Reset values: pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0. All registers are 0 and the state is FETCH.
- mem_req rises in the first cycle after rst deasserts.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and !mem_ready.
  - A transfer completes on the edge where mem_req & mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - mem_req drops in the following cycle unless a new request starts.
- Cycles per instruction with zero wait states (mem_ready tied high): LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each wait state adds 1 cycle to FETCH, MEMRD or MEMWR.
- pc updates at the end of FETCH (to PC+4), BRANCH (if taken) and JUMP.
- halted and illegal assert in the cycle after the HALT state is entered.
- rst asserted mid-transfer: outputs return to their reset values immediately (asynchronous). The pending access is abandoned; the memory must tolerate a dropped mem_req.

## Configuration
- MULTICYCLE_BNE_EN:
  - Defined: opcode 0x05 (BNE) is decoded and goes to BRANCH; the branch is taken if A≠B, in 3 cycles.
  - Undefined: opcode 0x05 → HALT with illegal=1.

## Test plan
- LW/SW round trip: program `addi $1,$0,0x40; addi $2,$0,-5; sw $2,0($1); lw $3,0($1); HALT` with zero-wait memory → mem[0x40]=0xFFFFFFFB, R3=0xFFFFFFFB, halted=1 after 4+4+4+5+3 = 20 cycles.
- R-type: R1=7, R2=9 → ADD gives 16, SUB gives 0xFFFFFFFE, AND gives 1, OR gives 15, SLT $4,$2,$1 gives 0. `add $0,$1,$2` leaves R0=0.
- Branches: BEQ with equal operands and imm=2 → pc=old+12; unequal → pc=old+4. J addr26=0x10 → pc=0x40.
- Wait states: mem_ready randomly low for 0–3 cycles → same architectural results. mem_addr/mem_we/mem_wdata are never seen changing while mem_req & !mem_ready.
- Illegal opcode: opcode 0x3F → halted=1, illegal=1, mem_req stays 0. BNE (0x05) is illegal only when MULTICYCLE_BNE_EN is undefined.
- Reset mid-MEMRD (rst low while waiting on mem_ready) → mem_req=0 and pc=RESET_PC immediately. Re-fetch from RESET_PC after release.
